// File: rtl/mdu_sequencer.sv
// Iterative unsigned multiply/divide sequencer: shift-add multiply and restoring
// divide, one pass through a shared (N+1)-bit adder per clock.

module adder #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] add1,
   input  logic [WIDTH-1:0] add0,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum
);
   assign sum = add1 + add0 + WIDTH'(carry_in);
endmodule

module mdu_sequencer #(
   parameter int unsigned parallelism = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   op,
   input  logic [parallelism-1:0] opA,
   input  logic [parallelism-1:0] opB,
   output logic                   busy,
   output logic                   done,
   output logic [parallelism-1:0] result_hi,
   output logic [parallelism-1:0] result_lo,
   output logic                   div_by_zero
);
   localparam int unsigned N  = parallelism;
   localparam int unsigned W  = N + 1;
   localparam int unsigned CW = $clog2(N) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [W-1:0]    r;
   logic [N-1:0]    q;
   logic [N-1:0]    b;
   logic            op_r;
   logic [CW-1:0]   cnt;

   logic [W-1:0]    add1;
   logic [W-1:0]    add0;
   logic            carry_in;
   logic [W-1:0]    sum;
   logic [W-1:0]    div_s;
   logic [W-1:0]    r_nxt;
   logic [N-1:0]    q_nxt;

   adder #(.WIDTH(W)) u_adder (
      .add1     (add1),
      .add0     (add0),
      .carry_in (carry_in),
      .sum      (sum)
   );

   // Adder operand select: conditional add for multiply, S - B for divide.
   always_comb begin
      add1     = '0;
      add0     = '0;
      carry_in = 1'b0;
      div_s    = {r[N-1:0], q[N-1]};
      if (op_r) begin
         add1     = div_s;
         add0     = ~{1'b0, b};
         carry_in = 1'b1;
      end else begin
         add1 = {1'b0, r[N-1:0]};
         add0 = q[0] ? {1'b0, b} : '0;
      end
   end

   // Next partial-result values; sum[N] clear means S >= B (restore not needed).
   always_comb begin
      r_nxt = r;
      q_nxt = q;
      if (op_r) begin
         if (!sum[N]) begin
            r_nxt = sum;
            q_nxt = {q[N-2:0], 1'b1};
         end else begin
            r_nxt = div_s;
            q_nxt = {q[N-2:0], 1'b0};
         end
      end else begin
         r_nxt = {1'b0, sum[N:1]};
         q_nxt = {sum[0], q[N-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         b           <= '0;
         op_r        <= 1'b0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result_hi   <= '0;
         result_lo   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  r           <= '0;
                  q           <= opA;
                  b           <= opB;
                  cnt         <= '0;
                  op_r        <= op;
                  div_by_zero <= 1'b0;
                  if (op && (opB == '0)) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     result_hi   <= opA;
                     result_lo   <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  result_hi <= r_nxt[N-1:0];
                  result_lo <= q_nxt;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed, table-driven bench for mdu_sequencer (N=4) plus hand-written
// mid-RUN start, back-to-back and asynchronous-reset sequences.

module tb_mdu_sequencer;
   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [N-1:0] opA;
   logic [N-1:0] opB;
   logic         busy;
   logic         done;
   logic [N-1:0] result_hi;
   logic [N-1:0] result_lo;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         op;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      logic         dbz;
      int           lat;
   } vec_t;

   vec_t vecs[11];

   mdu_sequencer #(.parallelism(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .opA         (opA),
      .opB         (opB),
      .busy        (busy),
      .done        (done),
      .result_hi   (result_hi),
      .result_lo   (result_lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Present a request at the negedge; returns #1 after the accepting edge.
   task automatic issue(input logic o, input logic [N-1:0] a, input logic [N-1:0] bb);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      opA   = a;
      opB   = bb;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Waits (bounded) for done; lat0 = edges already elapsed since acceptance.
   task automatic wait_done(input int lat0, input int exp_lat, input string nm);
      int lat;
      lat = lat0;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 4'd3,  4'd5, 4'h0, 4'hF, 1'b0, 5};
      vecs[1]  = '{1'b0, 4'd15, 4'd15, 4'hE, 4'h1, 1'b0, 5};
      vecs[2]  = '{1'b0, 4'd0,  4'd9, 4'h0, 4'h0, 1'b0, 5};
      vecs[3]  = '{1'b0, 4'd10, 4'd12, 4'h7, 4'h8, 1'b0, 5};
      vecs[4]  = '{1'b1, 4'd13, 4'd3, 4'h1, 4'h4, 1'b0, 5};
      vecs[5]  = '{1'b1, 4'd15, 4'd1, 4'h0, 4'hF, 1'b0, 5};
      vecs[6]  = '{1'b1, 4'd2,  4'd7, 4'h2, 4'h0, 1'b0, 5};
      vecs[7]  = '{1'b1, 4'd7,  4'd0, 4'h7, 4'hF, 1'b1, 1};
      vecs[8]  = '{1'b1, 4'd9,  4'd9, 4'h0, 4'h1, 1'b0, 5};
      vecs[9]  = '{1'b1, 4'd14, 4'd4, 4'h2, 4'h3, 1'b0, 5};
      vecs[10] = '{1'b0, 4'd7,  4'd9, 4'h3, 4'hF, 1'b0, 5};

      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      opA   = '0;
      opB   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_hi",   32'(result_hi), 32'd0);
      check("reset_lo",   32'(result_lo), 32'd0);
      check("reset_dbz",  32'(div_by_zero), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         if (vecs[i].dbz) check($sformatf("v%0d_dbz_busy", i), 32'(busy), 32'd0);
         wait_done(1, vecs[i].lat, $sformatf("v%0d", i));
         check($sformatf("v%0d_hi", i),  32'(result_hi), 32'(vecs[i].hi));
         check($sformatf("v%0d_lo", i),  32'(result_lo), 32'(vecs[i].lo));
         check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         check($sformatf("v%0d_hold_hi", i), 32'(result_hi), 32'(vecs[i].hi));
         check($sformatf("v%0d_hold_lo", i), 32'(result_lo), 32'(vecs[i].lo));
      end

      // start pulsed mid-RUN with different operands must be ignored
      issue(1'b0, 4'd3, 4'd5);
      @(negedge clk);
      start = 1'b1; op = 1'b1; opA = 4'd9; opB = 4'd0;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(2, 5, "midrun");
      check("midrun_hi",  32'(result_hi), 32'h0);
      check("midrun_lo",  32'(result_lo), 32'hF);
      check("midrun_dbz", 32'(div_by_zero), 32'd0);

      // back-to-back: second start presented during the done cycle
      issue(1'b0, 4'd15, 4'd15);
      wait_done(1, 5, "b2b_first");
      check("b2b_first_lo", 32'(result_lo), 32'h1);
      @(negedge clk);
      start = 1'b1; op = 1'b1; opA = 4'd13; opB = 4'd3;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_busy_rise", 32'(busy), 32'd1);
      check("b2b_done_low",  32'(done), 32'd0);
      wait_done(1, 5, "b2b_second");
      check("b2b_second_hi", 32'(result_hi), 32'h1);
      check("b2b_second_lo", 32'(result_lo), 32'h4);

      // asynchronous reset during iteration 2 aborts with no done
      issue(1'b0, 4'd15, 4'd15);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      check("rst_mid_hi",   32'(result_hi), 32'd0);
      check("rst_mid_lo",   32'(result_lo), 32'd0);
      check("rst_mid_dbz",  32'(div_by_zero), 32'd0);
      begin
         int saw_done;
         saw_done = 0;
         repeat (3) @(posedge clk);
         @(negedge clk) rst_n = 1'b1;
         for (int c = 0; c < N + 2; c++) begin
            @(posedge clk);
            #1 if (done || busy) saw_done = 1;
         end
         check("rst_no_done", 32'(saw_done), 32'd0);
      end
      issue(1'b1, 4'd14, 4'd4);
      wait_done(1, 5, "post_rst");
      check("post_rst_hi", 32'(result_hi), 32'h2);
      check("post_rst_lo", 32'(result_lo), 32'h3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
